div_iter: RTL and testbench

- Iterative 32-bit signed/unsigned divider in the EX stage; one quotient bit per cycle.
- Feeds the pipeline controller's EX stall request (stallreq_for_ex) while a divide is in flight, so the controller freezes PC/IF/ID/EX until the result is ready.
- Result goes to the HI/LO write path: remainder to HI, quotient to LO.

---
 rtl/div_iter_pkg.sv | 16 +
 rtl/div_iter_if.sv | 26 ++
 rtl/div_abs_neg.sv | 14 +
 rtl/div_iter.sv | 137 +++++++++++++
 tb/tb_div_iter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/div_iter_pkg.sv
// Shared definitions for the EX-stage divider.
// Holds the divider FSM encodings and the bus widths used by the HI/LO path
// and the pipeline stall controller.
package div_iter_pkg;

    localparam int unsigned StallBus     = 6;
    localparam int unsigned DivResultBus = 64;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_iter_if.sv
// Handshake between the EX stage and the iterative divider.
//   start, signed_div, opdata1, opdata2, annul : EX -> divider
//   result, ready                              : divider -> HI/LO write path
//   stallreq_for_ex                            : divider -> pipeline controller
interface div_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start;
    logic               signed_div;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic               annul;
    logic [2*WIDTH-1:0] result;
    logic               ready;
    logic               stallreq_for_ex;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  result, ready, stallreq_for_ex
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output result, ready, stallreq_for_ex
    );
endinterface

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate.
//   din  : value in
//   neg  : 1 = output -din, 0 = pass through
//   dout : value out
// Used both for operand magnitudes and for the final sign fix-up.
module div_abs_neg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);
    assign dout = neg ? (~din + WIDTH'(1)) : din;
endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per cycle.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : slave side of div_iter_if (operands in, {rem, quot} + ready out,
//              EX stall request out)
// A non-zero divide takes 32 cycles in ON; ready pulses the cycle after the
// last step. Divide-by-zero returns 0 after one cycle.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic      clk,
    input logic      rst,
    div_iter_if.slave bus
);
    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH:0]   work_q, work_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               quot_neg_q, quot_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   op1_abs, op2_abs;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic [2*WIDTH:0]   work_sh, work_step;
    logic [WIDTH:0]     trial;

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_op1 (
        .din  (bus.opdata1),
        .neg  (bus.signed_div & bus.opdata1[WIDTH-1]),
        .dout (op1_abs)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_op2 (
        .din  (bus.opdata2),
        .neg  (bus.signed_div & bus.opdata2[WIDTH-1]),
        .dout (op2_abs)
    );

    // One restoring step; trial[WIDTH] set means the subtraction went negative.
    assign work_sh   = work_q << 1;
    assign trial     = work_sh[2*WIDTH:WIDTH] - {1'b0, divisor_q};
    assign work_step = trial[WIDTH] ? work_sh : {trial, work_sh[WIDTH-1:1], 1'b1};

    // Sign fix-up taken from the final step so the result is ready on entry to END.
    div_abs_neg #(.WIDTH(WIDTH)) u_fix_quot (
        .din  (work_step[WIDTH-1:0]),
        .neg  (quot_neg_q),
        .dout (quot_fix)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
        .din  (work_step[2*WIDTH-1:WIDTH]),
        .neg  (rem_neg_q),
        .dout (rem_fix)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        result_d   = result_q;
        ready_d    = 1'b0;

        if (bus.annul) begin
            // Flush wins everywhere; result is left as it was.
            state_d = DIV_IDLE;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (bus.start) begin
                        if (bus.opdata2 == '0) begin
                            state_d  = DIV_BYZERO;
                            result_d = '0;
                            ready_d  = 1'b1;
                        end else begin
                            state_d    = DIV_ON;
                            cnt_d      = '0;
                            work_d     = {{(WIDTH+1){1'b0}}, op1_abs};
                            divisor_d  = op2_abs;
                            quot_neg_d = bus.signed_div &
                                         (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                            rem_neg_d  = bus.signed_div & bus.opdata1[WIDTH-1];
                        end
                    end
                end
                DIV_ON: begin
                    work_d = work_step;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DIV_END;
                        result_d = {rem_fix, quot_fix};
                        ready_d  = 1'b1;
                    end
                end
                DIV_BYZERO, DIV_END: begin
                    state_d = DIV_IDLE;
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.result          = result_q;
    assign bus.ready           = ready_q;
    // Released in the ready cycle so EX can advance.
    assign bus.stallreq_for_ex = bus.start & ~ready_q & ~bus.annul;

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_iter_if #(.WIDTH(32)) bus ();

    div_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          exp_ready_at = -1;
    logic [63:0] exp_res_next = '0;
    logic [63:0] model_res    = '0;
    bit          checking     = 1'b0;

    // Reference: plain arithmetic, {remainder, quotient}; x/0 defined as 0.
    function automatic logic [63:0] model_div(logic [31:0] a, logic [31:0] b, logic sgn);
        logic [31:0] q, r;
        longint      sa, sb, lq, lr;
        if (b == 32'd0) return 64'd0;
        if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
        return {r, q};
    endfunction

    task automatic check64(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            model_res    = '0;
            exp_ready_at = -1;
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        logic exp_rdy;
        if (checking) begin
            exp_rdy = (cyc == exp_ready_at);
            if (exp_rdy) model_res = exp_res_next;
            check64("ready", {63'd0, bus.ready}, {63'd0, exp_rdy});
            check64("result", bus.result, model_res);
            check64("stallreq", {63'd0, bus.stallreq_for_ex},
                    {63'd0, bus.start & ~exp_rdy & ~bus.annul});
        end
    end

    // Called just after a posedge; leaves start high, returns just after the
    // posedge following the ready cycle.
    task automatic run_div(logic [31:0] a, logic [31:0] b, logic sgn,
                           logic [63:0] lit, bit scramble);
        int lat;
        lat = (b == 32'd0) ? 1 : 33;
        bus.start      = 1'b1;
        bus.signed_div = sgn;
        bus.opdata1    = a;
        bus.opdata2    = b;
        exp_res_next   = model_div(a, b, sgn);
        exp_ready_at   = cyc + lat;
        check64("model_pin", exp_res_next, lit);
        if (scramble && lat > 1) begin
            @(posedge clk);
            #1;
            bus.opdata1    = $urandom;
            bus.opdata2    = $urandom;
            bus.signed_div = ~sgn;
            repeat (lat - 1) @(posedge clk);
        end else begin
            repeat (lat) @(posedge clk);
        end
        @(negedge clk);
        check64("ready_lit", {63'd0, bus.ready}, 64'd1);
        check64("result_lit", bus.result, lit);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        bus.annul      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        check64("reset_result", bus.result, 64'd0);
        check64("reset_ready", {63'd0, bus.ready}, 64'd0);
        @(posedge clk);
        #1;

        run_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 1'b1);
        bus.start = 1'b0;
        @(posedge clk); #1;
        run_div(32'hFFFFFFF9, 32'h2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        bus.start = 1'b0;
        @(posedge clk); #1;
        run_div(32'hFFFFFFF9, 32'h2, 1'b0, 64'h00000001_7FFFFFFC, 1'b0);
        bus.start = 1'b0;
        @(posedge clk); #1;
        run_div(32'd5, 32'd0, 1'b0, 64'd0, 1'b0);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_div(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 1'b0);
        bus.start = 1'b0;
        @(posedge clk); #1;

        // Flush in the tenth ON cycle: no ready, result left alone.
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd1000;
        bus.opdata2    = 32'd3;
        exp_ready_at   = -1;
        repeat (10) @(posedge clk);
        #1;
        bus.annul = 1'b1;
        @(negedge clk);
        check64("annul_stall", {63'd0, bus.stallreq_for_ex}, 64'd0);
        @(posedge clk);
        #1;
        bus.annul = 1'b0;
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        // Overflow, then a back-to-back divide.
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 1'b0);
        run_div(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 1'b0);
        bus.start = 1'b0;
        @(posedge clk); #1;
        run_div(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 1'b0);
        bus.start = 1'b0;
        @(posedge clk); #1;

        // Reset 20 cycles into a divide.
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd50;
        bus.opdata2    = 32'd5;
        exp_ready_at   = -1;
        repeat (20) @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check64("rst_mid_result", bus.result, 64'd0);
        check64("rst_mid_ready", {63'd0, bus.ready}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        run_div(32'd20, 32'd6, 1'b0, 64'h00000002_00000003, 1'b0);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
